// File: rtl/fc_pkg.sv
// fc_pkg: shared types and defaults for the FC result capture path.
//   fc_sink_state_t  - result sink FSM states
//   FC_DATA_W        - result word width produced by fc_top_ip
//   FC_SINK_DEPTH    - default result FIFO depth
//   FC_SINK_TIMEOUT  - default COLLECT cycle budget
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        COLLECT,
        DONE
    } fc_sink_state_t;

    localparam int FC_DATA_W       = 32;
    localparam int FC_SINK_DEPTH   = 16;
    localparam int FC_SINK_TIMEOUT = 4096;

endpackage

// File: rtl/fc_sink_fifo.sv
// fc_sink_fifo: synchronous-write, registered-read FIFO for result words.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   flush         - zero pointers and count (contents left as-is)
//   wr_en/wr_data - write request; dropped when full
//   rd_en         - pop request; ignored when empty
//   rd_data       - registered popped word, holds between pops
//   rd_valid      - one-cycle qualifier for rd_data
//   count         - stored words; count == DEPTH means full
//   full, empty   - occupancy flags
module fc_sink_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Storage has no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are power-of-two wide, so they wrap on their own.
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok)
                rd_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/fc_result_sink.sv
// fc_result_sink: launches one fc_top_ip run, captures its out_en-qualified
// result words into a FIFO, flags completion or timeout, then lets the host
// pop the words one per cycle.
// Ports:
//   clk_i, rst_i         - clock, asynchronous active-high reset
//   arm_i                - host pulse starting a run (IDLE/DONE only)
//   fc_start_o           - one-cycle start pulse to fc_top_ip
//   fc_done_i            - completion from fc_top_ip
//   in_data_i, in_en_i   - result word stream from fc_top_ip
//   done_o               - high while results are available (DONE)
//   timeout_o, ovf_o     - sticky run-status flags, cleared on launch
//   count_o              - words currently stored
//   rd_req_i             - host pop request (DONE only)
//   rd_data_o, rd_valid_o- registered popped word and its qualifier
module fc_result_sink
    import fc_pkg::*;
#(
    parameter int DATA_W  = FC_DATA_W,
    parameter int DEPTH   = FC_SINK_DEPTH,
    parameter int TIMEOUT = FC_SINK_TIMEOUT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    arm_i,
    output logic                    fc_start_o,
    input  logic                    fc_done_i,
    input  logic [DATA_W-1:0]       in_data_i,
    input  logic                    in_en_i,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic                    ovf_o,
    output logic [$clog2(DEPTH):0]  count_o,
    input  logic                    rd_req_i,
    output logic [DATA_W-1:0]       rd_data_o,
    output logic                    rd_valid_o
);

    // One spare bit so the timer never wraps before the compare hits.
    localparam int TW = $clog2(TIMEOUT) + 1;

    fc_sink_state_t state;
    fc_sink_state_t state_next;
    logic [TW-1:0]  timer;
    logic           launch_go;
    logic           capture;
    logic           timer_hit;
    logic           rd_en;
    logic           full;
    logic           empty;

    assign launch_go = arm_i && (state == IDLE || state == DONE);
    assign capture   = in_en_i && (state == LAUNCH || state == COLLECT);
    assign timer_hit = (state == COLLECT) && (timer == TW'(TIMEOUT - 1));
    assign rd_en     = rd_req_i && (state == DONE) && !empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arm_i) state_next = LAUNCH;
            LAUNCH:  state_next = COLLECT;
            COLLECT: if (fc_done_i || timer_hit) state_next = DONE;
            DONE:    if (arm_i) state_next = LAUNCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer     <= '0;
            ovf_o     <= 1'b0;
            timeout_o <= 1'b0;
        end else if (launch_go) begin
            timer     <= '0;
            ovf_o     <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            if (state == COLLECT)
                timer <= timer + 1'b1;
            if (capture && full)
                ovf_o <= 1'b1;
            // A done arriving on the last budgeted cycle counts as a normal finish.
            if (timer_hit && !fc_done_i)
                timeout_o <= 1'b1;
        end
    end

    assign fc_start_o = (state == LAUNCH);
    assign done_o     = (state == DONE);

    // Flush coincides with the edge that enters LAUNCH, so the LAUNCH-cycle
    // capture always lands in an empty FIFO.
    fc_sink_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (launch_go),
        .wr_en    (capture),
        .wr_data  (in_data_i),
        .rd_en    (rd_en),
        .rd_data  (rd_data_o),
        .rd_valid (rd_valid_o),
        .count    (count_o),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_fc_result_sink.sv
module tb_fc_result_sink;
    import fc_pkg::*;

    localparam int DW       = 32;
    localparam int DEPTH    = 16;
    localparam int TO_MAIN  = 64;
    localparam int TO_SHORT = 8;

    logic          clk = 1'b0;
    logic          rst, arm, fc_done, in_en, rd_req;
    logic [DW-1:0] in_data;

    logic          fc_start, done, timeout, ovf, rd_valid;
    logic [4:0]    count;
    logic [DW-1:0] rd_data;

    logic          t_fc_start, t_done, t_timeout, t_ovf, t_rd_valid;
    logic [4:0]    t_count;
    logic [DW-1:0] t_rd_data;

    always #5 clk = ~clk;

    fc_result_sink #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO_MAIN)) dut (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .fc_start_o(fc_start),
        .fc_done_i(fc_done), .in_data_i(in_data), .in_en_i(in_en),
        .done_o(done), .timeout_o(timeout), .ovf_o(ovf), .count_o(count),
        .rd_req_i(rd_req), .rd_data_o(rd_data), .rd_valid_o(rd_valid)
    );

    // Short-timeout instance sharing the same stimulus, used for timer checks.
    fc_result_sink #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO_SHORT)) dut_to (
        .clk_i(clk), .rst_i(rst), .arm_i(arm), .fc_start_o(t_fc_start),
        .fc_done_i(fc_done), .in_data_i(in_data), .in_en_i(in_en),
        .done_o(t_done), .timeout_o(t_timeout), .ovf_o(t_ovf), .count_o(t_count),
        .rd_req_i(rd_req), .rd_data_o(t_rd_data), .rd_valid_o(t_rd_valid)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          starts = 0;
    int          snap;
    int          model_cnt;
    logic [31:0] sb [$];
    logic [31:0] sb_exp;

    typedef struct {
        int          nw;
        logic [31:0] base;
        logic [31:0] step;
        bit          done_last;
        int          exp_cnt;
        bit          exp_ovf;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every popped word must match the oldest stored word.
    always @(negedge clk) begin
        if (fc_start)
            starts++;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
            end else begin
                sb_exp = sb.pop_front();
                check("rd_data", rd_data, sb_exp);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic arm_run;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        model_cnt = 0;
        check("fc_start_launch", {31'd0, fc_start}, 32'd1);
        tick();
    endtask

    task automatic stream(input int n, input logic [31:0] base, input logic [31:0] step,
                          input bit done_last);
        for (int i = 0; i < n; i++) begin
            in_en   = 1'b1;
            in_data = base + 32'(i) * step;
            fc_done = done_last && (i == n - 1);
            if (model_cnt < DEPTH) begin
                sb.push_back(in_data);
                model_cnt++;
            end
            tick();
        end
        in_en   = 1'b0;
        fc_done = 1'b0;
    endtask

    task automatic finish_run;
        fc_done = 1'b1;
        tick();
        fc_done = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check("rd_valid", {31'd0, rd_valid}, 32'd1);
        end
        rd_req = 1'b0;
        tick();
        check("rd_valid_after", {31'd0, rd_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{nw: 3,  base: 32'h11,   step: 32'h11, done_last: 1'b0, exp_cnt: 3,  exp_ovf: 1'b0};
        vecs[1] = '{nw: 18, base: 32'h100,  step: 32'h1,  done_last: 1'b0, exp_cnt: 16, exp_ovf: 1'b1};
        vecs[2] = '{nw: 1,  base: 32'hDEAD, step: 32'h0,  done_last: 1'b1, exp_cnt: 1,  exp_ovf: 1'b0};
        vecs[3] = '{nw: 16, base: 32'hA000, step: 32'h3,  done_last: 1'b1, exp_cnt: 16, exp_ovf: 1'b0};
        vecs[4] = '{nw: 0,  base: 32'h0,    step: 32'h0,  done_last: 1'b0, exp_cnt: 0,  exp_ovf: 1'b0};

        rst = 1'b1; arm = 1'b0; fc_done = 1'b0; in_en = 1'b0; rd_req = 1'b0; in_data = '0;
        model_cnt = 0;
        repeat (2) tick();
        check("rst_fc_start", {31'd0, fc_start}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        rst = 1'b0;
        tick();

        // Timeout: DONE exactly TIMEOUT cycles after entering COLLECT.
        snap = starts;
        arm_run();
        repeat (TO_SHORT - 1) tick();
        check("to_not_yet", {31'd0, t_done}, 32'd0);
        tick();
        check("to_done", {31'd0, t_done}, 32'd1);
        check("to_flag", {31'd0, t_timeout}, 32'd1);
        check("to_ovf", {31'd0, t_ovf}, 32'd0);
        check("main_still_collect", {31'd0, done}, 32'd0);
        finish_run();
        check("main_done", {31'd0, done}, 32'd1);
        check("main_one_start", 32'(starts - snap), 32'd1);

        // Done on the last budgeted cycle wins over timeout; re-arm clears flag.
        arm_run();
        check("to_cleared", {31'd0, t_timeout}, 32'd0);
        repeat (TO_SHORT - 1) tick();
        fc_done = 1'b1;
        tick();
        fc_done = 1'b0;
        check("tie_done", {31'd0, t_done}, 32'd1);
        check("tie_no_timeout", {31'd0, t_timeout}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            snap = starts;
            arm_run();
            stream(vecs[v].nw, vecs[v].base, vecs[v].step, vecs[v].done_last);
            if (!vecs[v].done_last)
                finish_run();
            check("vec_done", {31'd0, done}, 32'd1);
            check("vec_count", {27'd0, count}, 32'(vecs[v].exp_cnt));
            check("vec_ovf", {31'd0, ovf}, {31'd0, vecs[v].exp_ovf});
            check("vec_timeout", {31'd0, timeout}, 32'd0);
            check("vec_starts", 32'(starts - snap), 32'd1);
            drain(vecs[v].exp_cnt);
            check("vec_count_empty", {27'd0, count}, 32'd0);
            check("vec_sb_empty", 32'(sb.size()), 32'd0);
        end

        // Read while empty in DONE.
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("empty_read", {31'd0, rd_valid}, 32'd0);

        // Read and arm during COLLECT are ignored; then overflow, partial drain, re-arm.
        snap = starts;
        arm_run();
        stream(2, 32'h51, 32'h1, 1'b0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("collect_read", {31'd0, rd_valid}, 32'd0);
        check("collect_read_cnt", {27'd0, count}, 32'd2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        check("collect_arm_starts", 32'(starts - snap), 32'd1);
        check("collect_arm_done", {31'd0, done}, 32'd0);
        stream(15, 32'h60, 32'h1, 1'b1);
        check("ovf_count", {27'd0, count}, 32'd16);
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        drain(14);
        check("unread_count", {27'd0, count}, 32'd2);
        sb.delete();
        snap = starts;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("rearm_start", {31'd0, fc_start}, 32'd1);
        check("rearm_count", {27'd0, count}, 32'd0);
        check("rearm_ovf", {31'd0, ovf}, 32'd0);
        check("rearm_done", {31'd0, done}, 32'd0);
        tick();
        finish_run();
        check("rearm_end_count", {27'd0, count}, 32'd0);
        check("rearm_starts", 32'(starts - snap), 32'd1);

        // Reset mid-COLLECT after 5 words.
        arm_run();
        stream(5, 32'h200, 32'h1, 1'b0);
        rst = 1'b1;
        #1;
        check("mrst_fc_start", {31'd0, fc_start}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_timeout", {31'd0, timeout}, 32'd0);
        check("mrst_ovf", {31'd0, ovf}, 32'd0);
        check("mrst_count", {27'd0, count}, 32'd0);
        check("mrst_rd_data", rd_data, 32'd0);
        check("mrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        sb.delete();
        repeat (2) tick();
        rst = 1'b0;
        snap = starts;
        repeat (4) tick();
        check("post_rst_starts", 32'(starts - snap), 32'd0);
        check("post_rst_done", {31'd0, done}, 32'd0);
        check("post_rst_count", {27'd0, count}, 32'd0);

        // Still functional after reset.
        arm_run();
        stream(1, 32'h77, 32'h1, 1'b1);
        check("post_rst_run_cnt", {27'd0, count}, 32'd1);
        drain(1);
        check("post_rst_sb", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
